// File: rtl/cpu_pkg.sv
// Shared core constants and the next-PC select encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam int          DEF_RAS_DEPTH = 4;
  localparam int          INSTR_BYTES   = 4;

  // Which source feeds the PC register. HOLD is the stall case.
  typedef enum logic [2:0] {
    PCSEL_SEQ  = 3'd0,
    PCSEL_TGT  = 3'd1,
    PCSEL_JALR = 3'd2,
    PCSEL_RAS  = 3'd3,
    PCSEL_TRAP = 3'd4,
    PCSEL_HOLD = 3'd5
  } pcsel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Control/operand bundle between the core (master) and the PC unit (slave).
// Latency: n/a (wiring only).
// Backpressure: stall is the only hold mechanism; no handshake.
// Signals: stall/trap/branch/jal/jalr/call/ret, rs1/imm operands in;
//          pc, pc_plus4, pc_next, misalign, ras_empty, ras_full out.
interface pc_unit_if
  import cpu_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
);
  logic            stall;
  logic            trap;
  logic            branch;
  logic            jal;
  logic            jalr;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output stall, trap, branch, jal, jalr, call, ret, rs1, imm,
    input  pc, pc_plus4, pc_next, misalign, ras_empty, ras_full
  );

  modport slave (
    input  stall, trap, branch, jal, jalr, call, ret, rs1, imm,
    output pc, pc_plus4, pc_next, misalign, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack with push, pop and replace (push+pop) operations.
// Latency: push/pop take effect at the next edge; top entry is visible combinationally.
// Backpressure: none; push when full overwrites the oldest entry, pop when empty is ignored.
// Ports: i_clk, i_rst_n, i_push, i_pop, i_dat (push value), o_top_dat, o_empty, o_full.
module pc_ras
  import cpu_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int DEPTH = DEF_RAS_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_dat,
  output logic [XLEN-1:0] o_top_dat,
  output logic            o_empty,
  output logic            o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_top_inc;
  logic            w_pop_ok;

  // Pointer is a power-of-two width, so +1 wraps onto the oldest slot.
  assign w_top_inc = r_top + PW'(1);
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_top_dat = r_mem[r_top];
  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == FULL_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_top <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push && w_pop_ok) begin
      // Pop then push collapses to overwriting the current top.
      r_mem[r_top] <= i_dat;
    end else if (i_push) begin
      r_mem[w_top_inc] <= i_dat;
      r_top            <= w_top_inc;
      if (!o_full) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else if (w_pop_ok) begin
      r_top <= r_top - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC priority mux, internal target adders, trap/misalign redirect and RAS.
// Latency: PC takes pc_next at the next rising edge; pc_next/pc_plus4/misalign are combinational.
// Backpressure: stall holds PC and RAS for the cycle; trap overrides stall.
// Ports: i_clk, i_rst_n (async active-low), bus (pc_unit_if.slave: controls/operands in, PC status out).
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  pc_unit_if.slave   bus
);

  logic [XLEN-1:0] r_pc;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_tgt;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_ras_full;
  pcsel_e          w_sel;
  logic [XLEN-1:0] w_cand;
  logic            w_chk_align;
  logic            w_misalign;
  logic [XLEN-1:0] w_pc_next;
  logic            w_commit;
  logic            w_push;
  logic            w_pop;

  assign w_pc_plus4 = r_pc + XLEN'(INSTR_BYTES);
  assign w_br_tgt   = r_pc + bus.imm;
  assign w_jalr_sum = bus.rs1 + bus.imm;
  assign w_jalr_tgt = {w_jalr_sum[XLEN-1:1], 1'b0};

  // Priority: trap, stall, predicted return, jalr, branch/jal, sequential.
  always_comb begin
    w_sel = PCSEL_SEQ;
    if (bus.trap) begin
      w_sel = PCSEL_TRAP;
    end else if (bus.stall) begin
      w_sel = PCSEL_HOLD;
    end else if (bus.ret && bus.jalr && !w_ras_empty) begin
      w_sel = PCSEL_RAS;
    end else if (bus.jalr) begin
      w_sel = PCSEL_JALR;
    end else if (bus.branch || bus.jal) begin
      w_sel = PCSEL_TGT;
    end
  end

  // Only control-transfer targets are alignment-checked; seq/hold/trap are aligned by construction.
  always_comb begin
    w_cand      = w_pc_plus4;
    w_chk_align = 1'b0;
    unique case (w_sel)
      PCSEL_TRAP: w_cand = TRAP_VEC;
      PCSEL_HOLD: w_cand = r_pc;
      PCSEL_RAS: begin
        w_cand      = w_ras_top;
        w_chk_align = 1'b1;
      end
      PCSEL_JALR: begin
        w_cand      = w_jalr_tgt;
        w_chk_align = 1'b1;
      end
      PCSEL_TGT: begin
        w_cand      = w_br_tgt;
        w_chk_align = 1'b1;
      end
      PCSEL_SEQ: w_cand = w_pc_plus4;
      default:   w_cand = w_pc_plus4;
    endcase
  end

  assign w_misalign = w_chk_align && (w_cand[1:0] != 2'b00);
  assign w_pc_next  = w_misalign ? TRAP_VEC : w_cand;

  // RAS only moves on a jump that actually retires this cycle.
  assign w_commit = !bus.trap && !bus.stall && !w_misalign;
  assign w_push   = w_commit && bus.call && (bus.jal || bus.jalr);
  assign w_pop    = w_commit && bus.ret && bus.jalr && !w_ras_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_dat     (w_pc_plus4),
    .o_top_dat (w_ras_top),
    .o_empty   (w_ras_empty),
    .o_full    (w_ras_full)
  );

  assign bus.pc        = r_pc;
  assign bus.pc_plus4  = w_pc_plus4;
  assign bus.pc_next   = w_pc_next;
  assign bus.misalign  = w_misalign;
  assign bus.ras_empty = w_ras_empty;
  assign bus.ras_full  = w_ras_full;

endmodule
